clk_div_multi: RTL and testbench

//  Parametrised multi-channel programmable clock divider; successor to the fixed binary-tap divider.

---
 rtl/clk_div_multi.sv | 149 ++++++++++++++
 tb/tb_clk_div_multi.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider.
// Each channel divides clk by a runtime-loadable divisor D (D=0 behaves as D=1) and drives a
// one-cycle tick plus a near-50% square wave. New divisors are staged in a per-channel shadow
// register and only take effect at a period boundary (or immediately when the channel is idle),
// so a running output never shows a runt pulse. A global sync pulse restarts every channel at
// phase 0 so that channels with related divisors stay phase-aligned.

`timescale 1ns/1ps

// One divider channel: counter, shadow divisor and registered tick / square-wave outputs.
module clk_div_multi_ch #(
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic             enable,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] cnt;
    logic             started;

    logic [DIV_W-1:0] last;
    logic             running;
    logic             wrap;
    logic             apply;
    logic [DIV_W-1:0] div_next;
    logic [DIV_W-1:0] half_next;
    logic [DIV_W-1:0] cnt_next;
    logic             tick_next;
    logic             clk_out_next;
    logic             started_next;
    logic             pending_next;
    logic [DIV_W-1:0] shadow_next;

    // Work out this edge's phase, divisor hand-over and output levels.
    // The square wave is high for the first floor(D_eff/2) phases of a period, but only once the
    // channel has completed its first full period since it was (re)started.
    always_comb begin
        last         = (div == '0) ? '0 : div - DIV_W'(1);
        running      = enable && !sync;
        wrap         = running && (cnt == last);
        apply        = pending && (sync || !enable || wrap);
        div_next     = apply ? shadow : div;
        half_next    = ((div_next == '0) ? DIV_W'(1) : div_next) >> 1;

        cnt_next     = '0;
        tick_next    = 1'b0;
        clk_out_next = 1'b0;
        started_next = 1'b0;

        if (running) begin
            if (wrap) begin
                tick_next    = 1'b1;
                started_next = 1'b1;
                clk_out_next = (half_next != '0);
            end else begin
                cnt_next     = cnt + DIV_W'(1);
                started_next = started;
                clk_out_next = started && (cnt_next < half_next);
            end
        end

        shadow_next  = load ? load_div : shadow;
        pending_next = load ? 1'b1 : (apply ? 1'b0 : pending);
    end

    // Channel state and registered outputs; reset discards any staged divisor.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            div     <= DIV_W'(DEFAULT_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            cnt     <= '0;
            started <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            div     <= div_next;
            shadow  <= shadow_next;
            pending <= pending_next;
            cnt     <= cnt_next;
            started <= started_next;
            tick    <= tick_next;
            clk_out <= clk_out_next;
        end
    end

endmodule

// Top level: configuration handshake plus NUM_CH independent divider channels.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 50000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] accept;
    logic              ch_in_range;

    // Ready unless the addressed channel still holds an unapplied divisor; writes to channels
    // that do not exist are accepted and dropped so a bad address can never stall the master.
    always_comb begin
        ch_in_range = (int'(cfg_ch) < NUM_CH);
        cfg_ready   = ch_in_range ? !pending[cfg_ch] : 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i] = cfg_valid && ch_in_range && !pending[i] && (int'(cfg_ch) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_multi_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .RESETn   (RESETn),
            .enable   (ch_enable[g]),
            .sync     (sync),
            .load     (accept[g]),
            .load_div (cfg_div),
            .pending  (pending[g]),
            .tick     (tick[g]),
            .clk_out  (clk_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios with hand-computed timing expectations,
// followed by randomized traffic, all checked every cycle against a countdown-based model.

`timescale 1ns/1ps

module tb_clk_div_multi;

    localparam int NUM_CH  = 4;
    localparam int DIV_W   = 24;
    localparam int DEF_DIV = 500;
    localparam int CH_W    = 2;

    logic              clk = 1'b0;
    logic              RESETn;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] ch_enable;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    // Model: each channel counts down the edges left until its next tick.
    int                m_div    [NUM_CH];
    int                m_shadow [NUM_CH];
    int                m_left   [NUM_CH];
    bit                m_pend   [NUM_CH];
    bit                m_started[NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk       (clk),
        .RESETn    (RESETn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_enable (ch_enable),
        .sync      (sync),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #10 clk = ~clk;

    function automatic int deff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic model_ready(input int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]     = DEF_DIV;
            m_shadow[i]  = 0;
            m_left[i]    = DEF_DIV;
            m_pend[i]    = 1'b0;
            m_started[i] = 1'b0;
        end
        m_tick = '0;
        m_clk  = '0;
    endtask

    task automatic model_edge();
        int acc;
        int phase;
        if (RESETn !== 1'b1) return;
        acc = (cfg_valid && model_ready(int'(cfg_ch))) ? int'(cfg_ch) : -1;
        for (int i = 0; i < NUM_CH; i++) begin
            m_tick[i] = 1'b0;
            if (sync || !ch_enable[i]) begin
                if (m_pend[i]) begin
                    m_div[i]  = m_shadow[i];
                    m_pend[i] = 1'b0;
                end
                m_left[i]    = deff(m_div[i]);
                m_started[i] = 1'b0;
            end else begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_tick[i]    = 1'b1;
                    m_started[i] = 1'b1;
                    if (m_pend[i]) begin
                        m_div[i]  = m_shadow[i];
                        m_pend[i] = 1'b0;
                    end
                    m_left[i] = deff(m_div[i]);
                end
            end
            phase    = deff(m_div[i]) - m_left[i];
            m_clk[i] = m_started[i] && (phase < deff(m_div[i]) / 2);
            if (acc == i) begin
                m_shadow[i] = int'(cfg_div);
                m_pend[i]   = 1'b1;
            end
        end
    endtask

    task automatic check_output();
        check_value("tick", 32'(tick), 32'(m_tick));
        check_value("clk_out", 32'(clk_out), 32'(m_clk));
    endtask

    // One clock: ready check before the edge, model update at the edge, output check at negedge.
    task automatic step();
        #1;
        check_value("cfg_ready", 32'(cfg_ready), 32'(model_ready(int'(cfg_ch))));
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_output();
    endtask

    task automatic wait_tick(input int ch, input int limit);
        int n = 0;
        do begin
            step();
            n++;
        end while (tick[CH_W'(ch)] !== 1'b1 && n < limit);
        if (tick[CH_W'(ch)] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL wait_tick ch%0d: got no tick in %0d cycles, required one", ch, limit);
        end
    endtask

    task automatic cfg_write(input int ch, input int d);
        logic acc;
        int   n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(d);
        do begin
            acc = model_ready(ch);
            step();
            n++;
        end while (!acc && n < 200);
        cfg_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL cfg_write ch%0d: got no accept in %0d cycles, required accept", ch, n);
        end
    endtask

    task automatic apply_reset(input int hold);
        RESETn = 1'b0;
        #1;
        check_value("async_rst_tick", 32'(tick), 32'(0));
        check_value("async_rst_clk_out", 32'(clk_out), 32'(0));
        model_reset();
        repeat (hold) step();
        RESETn = 1'b1;
    endtask

    task automatic apply_stimulus();
        int b;
        for (int k = 0; k < 4000; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_div   = DIV_W'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) begin
                b = $urandom_range(0, NUM_CH - 1);
                ch_enable[CH_W'(b)] = ~ch_enable[CH_W'(b)];
            end
            sync = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 799) == 0) apply_reset(1);
            step();
        end
        cfg_valid = 1'b0;
        sync      = 1'b0;
    endtask

    initial begin
        int t0;
        int hi;
        int lo;
        int s;
        int first[NUM_CH];

        RESETn    = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        ch_enable = '0;
        sync      = 1'b0;
        model_reset();
        #5 RESETn = 1'b0;
        @(negedge clk);
        check_value("rst_tick", 32'(tick), 32'(0));
        check_value("rst_clk_out", 32'(clk_out), 32'(0));
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_ch = CH_W'(c);
            #1;
            check_value("rst_ready", 32'(cfg_ready), 32'(1));
        end
        cfg_ch = '0;
        repeat (2) step();
        RESETn = 1'b1;

        $display("[TB] default divisor on ch0");
        ch_enable = 4'b0001;
        t0 = cyc;
        wait_tick(0, 600);
        check_value("t1_first_tick", 32'(cyc - t0), 32'(500));
        hi = 0;
        while (clk_out[0] === 1'b1 && hi < 2000) begin hi++; step(); end
        lo = 0;
        while (tick[0] !== 1'b1 && lo < 2000) begin lo++; step(); end
        check_value("t1_high", 32'(hi), 32'(250));
        check_value("t1_low", 32'(lo), 32'(250));

        $display("[TB] enable drop, divisor change and mid-period reset on ch0");
        repeat (100) step();
        ch_enable[0] = 1'b0;
        step();
        check_value("t5_dis_tick", 32'(tick[0]), 32'(0));
        check_value("t5_dis_clk", 32'(clk_out[0]), 32'(0));
        repeat (9) step();
        ch_enable[0] = 1'b1;
        t0 = cyc;
        wait_tick(0, 600);
        check_value("t5_reenable", 32'(cyc - t0), 32'(500));
        cfg_write(0, 20);
        wait_tick(0, 600);
        t0 = cyc;
        wait_tick(0, 100);
        check_value("t5_new_period", 32'(cyc - t0), 32'(20));
        repeat (5) step();
        apply_reset(2);
        t0 = cyc;
        wait_tick(0, 600);
        check_value("t5_div_after_rst", 32'(cyc - t0), 32'(500));

        $display("[TB] divisor reload on running ch1");
        ch_enable = '0;
        cfg_write(1, 4);
        step();
        ch_enable = 4'b0010;
        t0 = cyc;
        wait_tick(1, 50);
        check_value("t2_first_d4", 32'(cyc - t0), 32'(4));
        t0 = cyc;
        cfg_write(1, 5);
        check_value("t2_ready_pending", 32'(cfg_ready), 32'(0));
        wait_tick(1, 50);
        check_value("t2_old_period", 32'(cyc - t0), 32'(4));
        check_value("t2_ready_after_wrap", 32'(cfg_ready), 32'(1));
        hi = 0;
        while (clk_out[1] === 1'b1 && hi < 50) begin hi++; step(); end
        lo = 0;
        while (tick[1] !== 1'b1 && lo < 50) begin lo++; step(); end
        check_value("t2_high", 32'(hi), 32'(2));
        check_value("t2_low", 32'(lo), 32'(3));

        $display("[TB] degenerate divisors on ch2");
        ch_enable = '0;
        cfg_write(2, 0);
        step();
        ch_enable = 4'b0100;
        step();
        check_value("t3_d0_tick", 32'(tick[2]), 32'(1));
        check_value("t3_d0_clk", 32'(clk_out[2]), 32'(0));
        repeat (3) step();
        check_value("t3_d0_tick_hold", 32'(tick[2]), 32'(1));
        cfg_write(2, 1);
        step();
        check_value("t3_d1_tick", 32'(tick[2]), 32'(1));
        check_value("t3_d1_clk", 32'(clk_out[2]), 32'(0));
        cfg_write(2, 2);
        step();
        check_value("t3_d2_clk_a", 32'(clk_out[2]), 32'(1));
        step();
        check_value("t3_d2_clk_b", 32'(clk_out[2]), 32'(0));
        check_value("t3_d2_tick_b", 32'(tick[2]), 32'(0));
        step();
        check_value("t3_d2_clk_c", 32'(clk_out[2]), 32'(1));

        $display("[TB] sync alignment on ch1..ch3");
        ch_enable = '0;
        cfg_write(1, 3);
        cfg_write(2, 4);
        cfg_write(3, 7);
        step();
        ch_enable = 4'b1110;
        repeat ($urandom_range(5, 12)) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_value("t4_sync_tick", 32'(tick & 4'b1110), 32'(0));
        check_value("t4_sync_clk", 32'(clk_out & 4'b1110), 32'(0));
        s = cyc;
        for (int c = 0; c < NUM_CH; c++) first[c] = -1;
        for (int k = 0; k < 8; k++) begin
            step();
            for (int c = 1; c < NUM_CH; c++) begin
                if (tick[CH_W'(c)] === 1'b1 && first[c] < 0) first[c] = cyc;
            end
        end
        check_value("t4_first_d3", 32'(first[1] - s), 32'(3));
        check_value("t4_first_d4", 32'(first[2] - s), 32'(4));
        check_value("t4_first_d7", 32'(first[3] - s), 32'(7));

        $display("[TB] back-to-back and on-wrap writes to ch3");
        wait_tick(3, 20);
        t0 = cyc;
        cfg_write(3, 6);
        check_value("t6_stall", 32'(cfg_ready), 32'(0));
        cfg_write(3, 9);
        check_value("t6_second_accept", 32'(cyc - t0), 32'(8));
        wait_tick(3, 20);
        check_value("t6_period6", 32'(cyc - t0), 32'(13));
        wait_tick(3, 20);
        check_value("t6_period9", 32'(cyc - t0), 32'(22));
        t0 = cyc;
        repeat (8) step();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_div   = DIV_W'(3);
        step();
        cfg_valid = 1'b0;
        check_value("t6_wrap_edge_tick", 32'(tick[3]), 32'(1));
        wait_tick(3, 20);
        check_value("t6_still9", 32'(cyc - t0), 32'(18));
        wait_tick(3, 20);
        check_value("t6_now3", 32'(cyc - t0), 32'(21));

        $display("[TB] randomized traffic");
        apply_stimulus();
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
